// File: rtl/fsum32_acc.sv
// fsum32_acc: streaming fp32 packet accumulator.
// Feeds an external combinational adder and emits per-packet totals.
module fsum32_acc #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_sub,
  input  logic             in_last,
  output logic             add_mode,
  output logic [31:0]      add_a,
  output logic [31:0]      add_b,
  input  logic [31:0]      add_res,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_nan,
  output logic             out_inf
);

  localparam logic [0:0] ACC  = 1'b0;
  localparam logic [0:0] DONE = 1'b1;

  logic [0:0]       state;
  logic [31:0]      acc;
  logic [CNT_W-1:0] count;
  logic             nan_q;
  logic             inf_q;
  logic             accept;
  logic             beat_nan;
  logic             beat_inf;

  function automatic logic is_nan(input logic [31:0] v);
    return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
  endfunction

  function automatic logic is_inf(input logic [31:0] v);
    return (v[30:23] == 8'hFF) && (v[22:0] == 23'd0);
  endfunction

  assign add_a    = acc;
  assign add_b    = in_data;
  assign add_mode = in_sub;

  assign in_ready  = (state == ACC);
  assign out_valid = (state == DONE);
  assign accept    = in_valid & in_ready;

  assign beat_nan = is_nan(in_data) | is_nan(add_res);
  assign beat_inf = is_inf(in_data) | is_inf(add_res);

  assign out_sum   = acc;
  assign out_count = count;
  assign out_nan   = nan_q;
  assign out_inf   = inf_q;

  // Accumulate beats in ACC, hold the total in DONE until taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACC;
      acc   <= 32'h0;
      count <= '0;
      nan_q <= 1'b0;
      inf_q <= 1'b0;
    end else begin
      unique case (1'b1)
        (state == ACC): begin
          if (accept) begin
            acc   <= add_res;
            nan_q <= nan_q | beat_nan;
            inf_q <= inf_q | beat_inf;
            if (count != {CNT_W{1'b1}})
              count <= count + CNT_W'(1);
            if (in_last)
              state <= DONE;
          end
        end
        (state == DONE): begin
          if (out_ready) begin
            state <= ACC;
            acc   <= 32'h0;
            count <= '0;
            nan_q <= 1'b0;
            inf_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
